// File: rtl/aes_pkg.sv
// Shared AES constants for the key-schedule blocks.
//   - Word/key/round-index widths.
//   - Engine state encoding (IDLE, EMIT).
//   - Round constant table and lookup helper, shared with the forward
//     key-expansion block.
package aes_pkg;

  localparam int WORD_W = 32;
  localparam int KEY_W  = 128;
  localparam int RND_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Rcon(1)..Rcon(10), first entry in the top byte.
  localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

  // Rcon word for round i: constant byte in [31:24], zero elsewhere.
  // Rounds outside 1..10 have no round constant.
  function automatic logic [WORD_W-1:0] rcon_word(input logic [RND_W-1:0] i);
    int idx;
    rcon_word = '0;
    if (i >= 4'd1 && i <= 4'd10) begin
      idx = 10 - int'(i);
      rcon_word = {RCON_TABLE[idx*8 +: 8], 24'h000000};
    end
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box, purely combinational.
//   i_byte : input byte
//   o_byte : substituted byte
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry 0 sits in the top byte, so entry x lives at bit (255-x)*8,
  // and 255-x is simply ~x for an 8-bit index.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = SBOX_TABLE[{~i_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 inverse key schedule.
// Takes the round-10 key and streams round keys 10 down to 0, one per
// output handshake, deriving each earlier key from the current one.
//   clk, rst_n : clock, asynchronous active-low reset
//   inKey      : round-10 key (w0 in [127:96]); inValid/inReady handshake
//   outKey     : current round key; outRnum its round index (10..0)
//   outLast    : high with round 0; outValid/outReady handshake
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int NROUNDS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_W-1:0]    inKey,
  input  logic                inValid,
  output logic                inReady,
  output logic [KEY_W-1:0]    outKey,
  output logic [RND_W-1:0]    outRnum,
  output logic                outLast,
  output logic                outValid,
  input  logic                outReady
);

  state_t              r_state;
  logic [KEY_W-1:0]    r_key;
  logic [RND_W-1:0]    r_rnd;
  logic                r_in_ready;
  logic                r_out_valid;

  logic [WORD_W-1:0]   w_w4, w_w5, w_w6, w_w7;
  logic [WORD_W-1:0]   w_p0, w_p1, w_p2, w_p3;
  logic [WORD_W-1:0]   w_rot, w_sub;
  logic [KEY_W-1:0]    w_prev_key;

  assign w_w4 = r_key[127:96];
  assign w_w5 = r_key[95:64];
  assign w_w6 = r_key[63:32];
  assign w_w7 = r_key[31:0];

  // Undo the forward XOR chain: each earlier word is the XOR of two
  // neighbouring later words. Only the first word needs the S-box term,
  // and it is computed from the recovered last word p3.
  assign w_p3 = w_w7 ^ w_w6;
  assign w_p2 = w_w6 ^ w_w5;
  assign w_p1 = w_w5 ^ w_w4;
  assign w_rot = {w_p3[23:0], w_p3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : gen_sbox
    aes_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  assign w_p0       = w_w4 ^ w_sub ^ rcon_word(r_rnd);
  assign w_prev_key = {w_p0, w_p1, w_p2, w_p3};

  // inReady is registered so that it stays low while reset is held and
  // rises on the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_key       <= '0;
      r_rnd       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (inValid && r_in_ready) begin
            r_key       <= inKey;
            r_rnd       <= RND_W'(NROUNDS);
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= EMIT;
          end
        end
        EMIT: begin
          if (outReady) begin
            if (r_rnd == '0) begin
              // Key and round index are left as they are; only the
              // handshake flags change.
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_key <= w_prev_key;
              r_rnd <= r_rnd - 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign inReady  = r_in_ready;
  assign outValid = r_out_valid;
  assign outKey   = r_key;
  assign outRnum  = r_rnd;
  // Gated by valid so the reset/idle value is 0 even though rnd is 0.
  assign outLast  = r_out_valid && (r_rnd == '0);

endmodule
